// File: rtl/ms_pkg.sv
// Shared defaults, state encoding and cell address type for the minefield blocks.
package ms_pkg;
  localparam int DEF_ROW_W    = 4;
  localparam int DEF_COL_W    = 4;
  localparam int DEF_ROWS     = 16;
  localparam int DEF_COLS     = 16;
  localparam int DEF_MINE_CNT = 40;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_PLACE,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [DEF_ROW_W-1:0] row;
    logic [DEF_COL_W-1:0] col;
  } cell_t;
endpackage

// File: rtl/mine_occ_map.sv
// Per-cell occupancy bits (clear / set / test with same-cycle set bypass) and the safe-cell exclusion check.
// MINE_SAFE_NBR_EN widens the exclusion from the safe cell to its clipped 3x3 neighbourhood.
module mine_occ_map
  import ms_pkg::*;
#(
  parameter int ROW_W = DEF_ROW_W,
  parameter int COL_W = DEF_COL_W,
  parameter int ROWS  = DEF_ROWS,
  parameter int COLS  = DEF_COLS
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic [ROW_W-1:0] clr_row_i,
  input  logic [COL_W-1:0] clr_col_i,
  input  logic             set_i,
  input  logic [ROW_W-1:0] set_row_i,
  input  logic [COL_W-1:0] set_col_i,
  input  logic [ROW_W-1:0] test_row_i,
  input  logic [COL_W-1:0] test_col_i,
  input  logic [ROW_W-1:0] safe_row_i,
  input  logic [COL_W-1:0] safe_col_i,
  output logic             occ_o,
  output logic             excl_o
);
  localparam int CELLS = ROWS * COLS;
  localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;

  function automatic logic [IDX_W-1:0] cell_idx(input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c);
    return IDX_W'(int'(r) * COLS + int'(c));
  endfunction

  logic [CELLS-1:0] occ_q;
  logic [IDX_W-1:0] clr_idx, set_idx, test_idx;

  assign clr_idx  = cell_idx(clr_row_i, clr_col_i);
  assign set_idx  = cell_idx(set_row_i, set_col_i);
  assign test_idx = cell_idx(test_row_i, test_col_i);

  // Every run starts with a full CLEAR sweep, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      occ_q[clr_idx] <= 1'b0;
    end else if (set_i) begin
      occ_q[set_idx] <= 1'b1;
    end
  end

  assign occ_o = occ_q[test_idx] | (set_i & (set_idx == test_idx));

`ifdef MINE_SAFE_NBR_EN
  logic [ROW_W:0] tr, sr;
  logic [COL_W:0] tc, sc;
  assign tr = {1'b0, test_row_i};
  assign sr = {1'b0, safe_row_i};
  assign tc = {1'b0, test_col_i};
  assign sc = {1'b0, safe_col_i};
  assign excl_o = (tr + (ROW_W+1)'(1) >= sr) && (tr <= sr + (ROW_W+1)'(1)) &&
                  (tc + (COL_W+1)'(1) >= sc) && (tc <= sc + (COL_W+1)'(1));
`else
  assign excl_o = (test_row_i == safe_row_i) && (test_col_i == safe_col_i);
`endif
endmodule

// File: rtl/mine_place_ctrl.sv
// Clears the map RAM, then places MINE_CNT mines from the LFSR stream avoiding duplicates and the safe cell.
// Option macro: MINE_SAFE_NBR_EN (exclude the 3x3 block around the safe cell instead of the cell alone).
module mine_place_ctrl
  import ms_pkg::*;
#(
  parameter int ROW_W    = DEF_ROW_W,
  parameter int COL_W    = DEF_COL_W,
  parameter int ROWS     = DEF_ROWS,
  parameter int COLS     = DEF_COLS,
  parameter int MINE_CNT = DEF_MINE_CNT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [ROW_W-1:0]       safe_row_i,
  input  logic [COL_W-1:0]       safe_col_i,
  input  logic [ROW_W+COL_W-1:0] rnd_i,
  output logic                   map_we_o,
  output logic [ROW_W+COL_W-1:0] map_addr_o,
  output logic                   map_din_o,
  output logic                   busy_o,
  output logic                   done_o
);
  localparam int AW    = ROW_W + COL_W;
  localparam int CNT_W = $clog2(MINE_CNT + 1);
  localparam logic [ROW_W:0]   ROWS_L   = (ROW_W+1)'(ROWS);
  localparam logic [COL_W:0]   COLS_L   = (COL_W+1)'(COLS);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  localparam logic [CNT_W-1:0] LAST_MINE = CNT_W'(MINE_CNT - 1);

  if (MINE_CNT > ROWS * COLS - 9) begin : g_cnt_chk
    $error("MINE_CNT must not exceed ROWS*COLS-9");
  end

  state_t           state_q, state_d;
  logic [ROW_W-1:0] safe_row_q, safe_row_d, clr_row_q, clr_row_d;
  logic [COL_W-1:0] safe_col_q, safe_col_d, clr_col_q, clr_col_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             we_q, we_d, din_q, din_d, busy_q, busy_d, done_q, done_d;
  logic [ROW_W-1:0] cand_row;
  logic [COL_W-1:0] cand_col;
  logic             in_range, cand_occ, cand_excl;

  assign cand_row = rnd_i[AW-1:COL_W];
  assign cand_col = rnd_i[COL_W-1:0];
  assign in_range = ({1'b0, cand_row} < ROWS_L) && ({1'b0, cand_col} < COLS_L);

  // Occupancy is set from the registered mine write; the bypass covers the candidate one cycle later.
  mine_occ_map #(.ROW_W(ROW_W), .COL_W(COL_W), .ROWS(ROWS), .COLS(COLS)) u_occ (
    .clk       (clk),
    .clr_i     (state_q == ST_CLEAR),
    .clr_row_i (clr_row_q),
    .clr_col_i (clr_col_q),
    .set_i     (we_q & din_q),
    .set_row_i (addr_q[AW-1:COL_W]),
    .set_col_i (addr_q[COL_W-1:0]),
    .test_row_i(cand_row),
    .test_col_i(cand_col),
    .safe_row_i(safe_row_q),
    .safe_col_i(safe_col_q),
    .occ_o     (cand_occ),
    .excl_o    (cand_excl)
  );

  always_comb begin
    state_d    = state_q;
    safe_row_d = safe_row_q;
    safe_col_d = safe_col_q;
    clr_row_d  = clr_row_q;
    clr_col_d  = clr_col_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    we_d       = 1'b0;
    din_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d    = ST_CLEAR;
          safe_row_d = safe_row_i;
          safe_col_d = safe_col_i;
          clr_row_d  = '0;
          clr_col_d  = '0;
          cnt_d      = '0;
        end
      end
      ST_CLEAR: begin
        we_d   = 1'b1;
        addr_d = {clr_row_q, clr_col_q};
        if (clr_col_q == LAST_COL) begin
          clr_col_d = '0;
          if (clr_row_q == LAST_ROW) state_d = ST_PLACE;
          else                       clr_row_d = clr_row_q + ROW_W'(1);
        end else begin
          clr_col_d = clr_col_q + COL_W'(1);
        end
      end
      ST_PLACE: begin
        if (in_range && !cand_occ && !cand_excl) begin
          we_d   = 1'b1;
          din_d  = 1'b1;
          addr_d = rnd_i;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_MINE) state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_CLEAR) || (state_d == ST_PLACE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      safe_row_q <= '0;
      safe_col_q <= '0;
      clr_row_q  <= '0;
      clr_col_q  <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      din_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      safe_row_q <= safe_row_d;
      safe_col_q <= safe_col_d;
      clr_row_q  <= clr_row_d;
      clr_col_q  <= clr_col_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      din_q      <= din_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign map_we_o   = we_q;
  assign map_addr_o = addr_q;
  assign map_din_o  = din_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
endmodule

// File: tb/tb_mine_place_ctrl.sv
// Scoreboarded bench: a 16x16 instance and a 10x12 instance driven with directed and seeded candidate streams.
module tb_mine_place_ctrl;
  import ms_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start0, start1;
  logic [3:0] sr0, sc0, sr1, sc1;
  logic [7:0] rnd0, rnd1;
  logic       we0, din0, busy0, done0, we1, din1, busy1, done1;
  logic [7:0] addr0, addr1;

  always #5 clk = ~clk;

  mine_place_ctrl dut0 (
    .clk(clk), .rst(rst), .start_i(start0), .safe_row_i(sr0), .safe_col_i(sc0), .rnd_i(rnd0),
    .map_we_o(we0), .map_addr_o(addr0), .map_din_o(din0), .busy_o(busy0), .done_o(done0)
  );

  mine_place_ctrl #(.ROWS(10), .COLS(12)) dut1 (
    .clk(clk), .rst(rst), .start_i(start1), .safe_row_i(sr1), .safe_col_i(sc1), .rnd_i(rnd1),
    .map_we_o(we1), .map_addr_o(addr1), .map_din_o(din1), .busy_o(busy1), .done_o(done1)
  );

  typedef struct packed {
    logic       is_done;
    logic [7:0] addr;
    logic       din;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   total = 0;
  int   bad = 0;
  bit   occ[2][256];
  int   cnt[2];
  int   mine_seen[2];
  bit   active[2];
  int   rows_m[2] = '{16, 10};
  int   cols_m[2] = '{16, 12};
  int   msr[2], msc[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int inst, input exp_t e);
    if (inst == 0) q0.push_back(e);
    else           q1.push_back(e);
  endtask

  task automatic pop_chk(input int inst, input bit is_done, input logic [7:0] addr, input logic din);
    exp_t e;
    total++;
    if ((inst == 0 && q0.size() == 0) || (inst == 1 && q1.size() == 0)) begin
      bad++;
      $display("FAIL unexpected_out%0d: got done=%0b addr=%02h din=%0b, expected nothing", inst, is_done, addr, din);
      return;
    end
    if (inst == 0) e = q0.pop_front();
    else           e = q1.pop_front();
    if (e.is_done !== is_done || (!is_done && (e.addr !== addr || e.din !== din))) begin
      bad++;
      $display("FAIL out%0d: got done=%0b addr=%02h din=%0b, expected done=%0b addr=%02h din=%0b",
               inst, is_done, addr, din, e.is_done, e.addr, e.din);
    end
  endtask

  task automatic mon(input int inst, input logic we, input logic [7:0] addr, input logic din, input logic done);
    if (we) begin
      pop_chk(inst, 1'b0, addr, din);
      if (din) mine_seen[inst]++;
      if (inst == 1) chk("range10x12", 32'(addr[7:4] < 4'd10 && addr[3:0] < 4'd12), 32'd1);
    end
    if (done) pop_chk(inst, 1'b1, 8'h00, 1'b0);
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      mon(0, we0, addr0, din0, done0);
      mon(1, we1, addr1, din1, done1);
    end
  end

  task automatic model_start(input int inst, input logic [3:0] r, input logic [3:0] c);
    exp_t e;
    active[inst]    = 1'b1;
    cnt[inst]       = 0;
    mine_seen[inst] = 0;
    msr[inst]       = int'(r);
    msc[inst]       = int'(c);
    for (int i = 0; i < 256; i++) occ[inst][i] = 1'b0;
    for (int rr = 0; rr < rows_m[inst]; rr++)
      for (int cc = 0; cc < cols_m[inst]; cc++) begin
        e = '{is_done: 1'b0, addr: 8'((rr << 4) | cc), din: 1'b0};
        push_exp(inst, e);
      end
  endtask

  task automatic model_cand(input int inst, input logic [7:0] cand);
    int r, c;
    bit ex;
    exp_t e;
    if (!active[inst]) return;
    r = int'(cand[7:4]);
    c = int'(cand[3:0]);
    if (r >= rows_m[inst] || c >= cols_m[inst]) return;
    if (occ[inst][cand]) return;
`ifdef MINE_SAFE_NBR_EN
    ex = (r >= msr[inst] - 1) && (r <= msr[inst] + 1) && (c >= msc[inst] - 1) && (c <= msc[inst] + 1);
`else
    ex = (r == msr[inst]) && (c == msc[inst]);
`endif
    if (ex) return;
    occ[inst][cand] = 1'b1;
    cnt[inst]++;
    e = '{is_done: 1'b0, addr: cand, din: 1'b1};
    push_exp(inst, e);
    if (cnt[inst] == 40) begin
      e = '{is_done: 1'b1, addr: 8'h00, din: 1'b0};
      push_exp(inst, e);
      active[inst] = 1'b0;
    end
  endtask

  task automatic run_start(input int inst, input logic [3:0] r, input logic [3:0] c);
    if (inst == 0) begin start0 = 1'b1; sr0 = r; sc0 = c; end
    else           begin start1 = 1'b1; sr1 = r; sc1 = c; end
    model_start(inst, r, c);
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    repeat (rows_m[inst] * cols_m[inst]) @(negedge clk);
  endtask

  task automatic feed(input int inst, input logic [7:0] cand);
    if (inst == 0) rnd0 = cand;
    else           rnd1 = cand;
    model_cand(inst, cand);
    @(negedge clk);
  endtask

  task automatic run_end(input int inst, input string name);
    repeat (3) @(negedge clk);
    chk({name, "_mines"}, 32'(mine_seen[inst]), 32'd40);
    chk({name, "_pending"}, 32'(inst == 0 ? q0.size() : q1.size()), 32'd0);
    chk({name, "_idle"}, 32'(inst == 0 ? busy0 : busy1), 32'd0);
  endtask

  task automatic fill_pattern(input int inst, input string name);
    int k = 0;
    while (active[inst] && k < 1000) begin
      feed(inst, 8'(k * 37 + 11));
      k++;
    end
    chk({name, "_timeout"}, 32'(active[inst]), 32'd0);
  endtask

  task automatic fill_random(input int inst, input string name);
    logic [7:0] near[7] = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h02, 8'h20, 8'h22};
    int k = 0;
    while (active[inst] && k < 2000) begin
      if ($urandom_range(0, 3) == 0) feed(inst, near[$urandom_range(0, 6)]);
      else                           feed(inst, 8'($urandom_range(0, 255)));
      k++;
    end
    chk({name, "_timeout"}, 32'(active[inst]), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
    sr0 = '0; sc0 = '0; sr1 = '0; sc1 = '0; rnd0 = '0; rnd1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_we", 32'(we0), 32'd0);
    chk("rst_addr", 32'(addr0), 32'd0);
    chk("rst_din", 32'(din0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_busy1", 32'(busy1), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Run A: safe (3,3), directed rejects, mid-PLACE start and start in DONE cycle.
    run_start(0, 4'd3, 4'd3);
    chk("runA_busy", 32'(busy0), 32'd1);
    repeat (10) feed(0, 8'h33);
    chk("safe_no_write", 32'(mine_seen[0]), 32'd0);
    repeat (3) feed(0, 8'h57);
    chk("dup_one_write", 32'(mine_seen[0]), 32'd1);
    k = 0;
    while (active[0] && k < 1000) begin
      if (k == 10) start0 = 1'b1;
      feed(0, 8'(k * 37 + 11));
      start0 = 1'b0;
      k++;
    end
    chk("runA_timeout", 32'(active[0]), 32'd0);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    run_end(0, "runA");

    // Run B: abort by reset at the 20th mine, then a clean restart.
    run_start(0, 4'd5, 4'd9);
    k = 0;
    while (cnt[0] < 20 && k < 1000) begin
      feed(0, 8'(k * 53 + 7));
      k++;
    end
    rst = 1'b1;
    q0.delete();
    active[0] = 1'b0;
    rnd0 = 8'hE1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_busy", 32'(busy0), 32'd0);
    chk("abort_done", 32'(done0), 32'd0);
    chk("abort_we", 32'(we0), 32'd0);
    run_start(0, 4'd8, 4'd2);
    fill_pattern(0, "runC");
    run_end(0, "runC");

    // 10x12 map: out-of-range candidates are dropped.
    run_start(1, 4'd4, 4'd4);
    feed(1, 8'hA5);
    feed(1, 8'h3C);
    feed(1, 8'hA5);
    chk("oor_no_write", 32'(mine_seen[1]), 32'd0);
    fill_random(1, "small");
    run_end(1, "small");

    // Seeded runs with the safe cell in the corner.
    for (int run = 0; run < 100; run++) begin
      run_start(0, 4'd0, 4'd0);
      fill_random(0, "corner");
      repeat (2) @(negedge clk);
      chk("corner_mines", 32'(mine_seen[0]), 32'd40);
    end
    run_end(0, "corner_last");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
